// File: rtl/reg_file_loader.sv
// reg_file_loader: turns a valid/ready byte-stream of packets into write strobes for the
// register file, and clears every register after reset or on request. Macro REG0_PROTECT_EN.
module reg_file_loader #(
  parameter int pw = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic [pw:0]   wr_addr,
  output logic          wr_en,
  output logic [7:0]    wr_dat,
  output logic          busy,
  output logic          pkt_done,
  output logic          err_addr
);

  localparam int NREG = 2 ** pw;

  typedef logic [pw:0]   addr_t;
  typedef logic [pw-1:0] idx_t;

  localparam addr_t LAST_ADDR = addr_t'(NREG - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_IDLE  = 2'd1,
    S_DATA  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  addr_t      cnt_q, cnt_d;
  addr_t      ptr_q, ptr_d;
  logic [3:0] rem_q, rem_d;
  logic       discard_q, discard_d;
  logic       err_q, err_d;
  logic       pend_q, pend_d;
  logic       wr_en_q, wr_en_d;
  addr_t      wr_addr_q, wr_addr_d;
  logic [7:0] wr_dat_q, wr_dat_d;
  logic       done_q, done_d;

  addr_t      hdr_addr;
  logic       data_wr_ok;

  // Header nibble is resized to the address bus; any value with the MSB set lies beyond NREG.
  assign hdr_addr = addr_t'(in_data[3:0]);

  always_comb begin
`ifdef REG0_PROTECT_EN
    data_wr_ok = !discard_q && (ptr_q != '0);
`else
    data_wr_ok = !discard_q;
`endif
  end

  // Handshake: a byte moves on a posedge where in_valid & in_ready. in_ready is a function
  // of state only (plus the clear request in IDLE); in_valid may drop on any cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    discard_d = discard_q;
    err_d     = err_q;
    pend_d    = pend_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_dat_d  = wr_dat_q;
    done_d    = 1'b0;
    in_ready  = 1'b0;

    case (state_q)
      S_CLEAR: begin
        // A request arriving mid-clear is already satisfied: nothing else writes meanwhile.
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q;
        wr_dat_d  = 8'h00;
        cnt_d     = cnt_q + addr_t'(1);
        if (cnt_q == LAST_ADDR) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        in_ready = !(clear_req || pend_q);
        if (clear_req || pend_q) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          err_d   = 1'b0;
          pend_d  = 1'b0;
        end else if (in_valid) begin
          state_d   = S_DATA;
          rem_d     = in_data[7:4];
          ptr_d     = hdr_addr;
          discard_d = hdr_addr[pw];
          if (hdr_addr[pw]) begin
            err_d = 1'b1;
          end
        end
      end

      S_DATA: begin
        in_ready = 1'b1;
        if (clear_req) begin
          pend_d = 1'b1;
        end
        if (in_valid) begin
          if (data_wr_ok) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_dat_d  = in_data;
          end
          ptr_d = {1'b0, idx_t'(ptr_q[pw-1:0] + idx_t'(1))};
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      default: begin
        state_d = S_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_CLEAR;
      cnt_q     <= '0;
      ptr_q     <= '0;
      rem_q     <= 4'd0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
      pend_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_dat_q  <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      discard_q <= discard_d;
      err_q     <= err_d;
      pend_q    <= pend_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_dat_q  <= wr_dat_d;
      done_q    <= done_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_dat   = wr_dat_q;
  assign pkt_done = done_q;
  assign err_addr = err_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_reg_file_loader.sv
// Directed bench for reg_file_loader (pw=3): reset clear, packets, wrap, bad address,
// deferred and simultaneous clear requests, reset mid-packet.
module tb_reg_file_loader;

  logic       clk;
  logic       rst_n;
  logic       clear_req;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [3:0] wr_addr;
  logic       wr_en;
  logic [7:0] wr_dat;
  logic       busy;
  logic       pkt_done;
  logic       err_addr;

  int vectors;
  int miscompares;

  reg_file_loader #(.pw(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_addr   (wr_addr),
    .wr_en     (wr_en),
    .wr_dat    (wr_dat),
    .busy      (busy),
    .pkt_done  (pkt_done),
    .err_addr  (err_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic chk_wr(input string tag, input logic en, input logic [3:0] addr,
                        input logic [7:0] dat, input logic done);
    check({tag, ".wr_en"}, wr_en, en);
    check({tag, ".pkt_done"}, pkt_done, done);
    if (en) begin
      check({tag, ".wr_addr"}, wr_addr, addr);
      check({tag, ".wr_dat"}, wr_dat, dat);
    end
  endtask

  task automatic clear_seq(input string tag);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk_wr($sformatf("%s.clr%0d", tag, i), 1'b1, 4'(i), 8'h00, 1'b0);
      if (i < 7) check($sformatf("%s.rdy%0d", tag, i), in_ready, 1'b0);
    end
    check({tag, ".busy_end"}, busy, 1'b0);
    check({tag, ".rdy_end"}, in_ready, 1'b1);
    cyc();
    check({tag, ".en_after"}, wr_en, 1'b0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    clear_req   = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;

    // Reset values
    cyc();
    cyc();
    check("rst.wr_en", wr_en, 1'b0);
    check("rst.wr_addr", wr_addr, 4'h0);
    check("rst.wr_dat", wr_dat, 8'h00);
    check("rst.in_ready", in_ready, 1'b0);
    check("rst.pkt_done", pkt_done, 1'b0);
    check("rst.err_addr", err_addr, 1'b0);
    check("rst.busy", busy, 1'b1);
    rst_n = 1'b1;
    clear_seq("init");

    // Simple two-byte packet at address 2
    send(8'h12);
    chk_wr("p1.hdr", 1'b0, 4'h0, 8'h00, 1'b0);
    send(8'hAA);
    chk_wr("p1.b0", 1'b1, 4'h2, 8'hAA, 1'b0);
    send(8'h55);
    chk_wr("p1.b1", 1'b1, 4'h3, 8'h55, 1'b1);
    check("p1.busy", busy, 1'b0);
    cyc();
    chk_wr("p1.idle", 1'b0, 4'h0, 8'h00, 1'b0);
    check("p1.hold_addr", wr_addr, 4'h3);
    check("p1.hold_dat", wr_dat, 8'h55);

    // Wrap 7 -> 0 -> 1 with two-cycle gaps between bytes
    send(8'h27);
    chk_wr("p2.hdr", 1'b0, 4'h0, 8'h00, 1'b0);
    send(8'h01);
    chk_wr("p2.b0", 1'b1, 4'h7, 8'h01, 1'b0);
    check("p2.rdy_gap", in_ready, 1'b1);
    cyc();
    chk_wr("p2.gap0", 1'b0, 4'h0, 8'h00, 1'b0);
    cyc();
    chk_wr("p2.gap1", 1'b0, 4'h0, 8'h00, 1'b0);
    send(8'h02);
    chk_wr("p2.b1", 1'b1, 4'h0, 8'h02, 1'b0);
    cyc();
    chk_wr("p2.gap2", 1'b0, 4'h0, 8'h00, 1'b0);
    cyc();
    chk_wr("p2.gap3", 1'b0, 4'h0, 8'h00, 1'b0);
    send(8'h03);
    chk_wr("p2.b2", 1'b1, 4'h1, 8'h03, 1'b1);

    // Out-of-range start address: consumed, discarded, sticky error
    send(8'h09);
    check("p3.err_hdr", err_addr, 1'b1);
    check("p3.en_hdr", wr_en, 1'b0);
    send(8'hFF);
    check("p3.en_data", wr_en, 1'b0);
    check("p3.busy", busy, 1'b0);
    check("p3.err_data", err_addr, 1'b1);
    send(8'h00);
    send(8'h5A);
`ifdef REG0_PROTECT_EN
    chk_wr("p4.b0", 1'b0, 4'h0, 8'h00, 1'b1);
`else
    chk_wr("p4.b0", 1'b1, 4'h0, 8'h5A, 1'b1);
`endif
    check("p4.err", err_addr, 1'b1);

    // clear_req during DATA is deferred until the packet completes
    send(8'h13);
    send(8'h11);
    chk_wr("p5.b0", 1'b1, 4'h3, 8'h11, 1'b0);
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    chk_wr("p5.gap", 1'b0, 4'h0, 8'h00, 1'b0);
    send(8'h22);
    chk_wr("p5.b1", 1'b1, 4'h4, 8'h22, 1'b1);
    check("p5.rdy_pend", in_ready, 1'b0);
    cyc();
    chk_wr("p5.enter", 1'b0, 4'h0, 8'h00, 1'b0);
    check("p5.busy", busy, 1'b1);
    check("p5.err_clr", err_addr, 1'b0);
    clear_seq("p5");

    // clear_req with a header in IDLE: clear wins, header not taken
    clear_req = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h12;
    #1;
    check("p6.rdy", in_ready, 1'b0);
    cyc();
    clear_req = 1'b0;
    in_valid  = 1'b0;
    chk_wr("p6.enter", 1'b0, 4'h0, 8'h00, 1'b0);
    check("p6.busy", busy, 1'b1);
    clear_seq("p6");

    // Reset after the first data byte abandons the packet
    send(8'h30);
    send(8'h77);
    chk_wr("p7.b0", 1'b1, 4'h0, 8'h77, 1'b0);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h88;
    cyc();
    in_valid = 1'b0;
    check("p7.rst_en", wr_en, 1'b0);
    check("p7.rst_addr", wr_addr, 4'h0);
    check("p7.rst_dat", wr_dat, 8'h00);
    check("p7.rst_busy", busy, 1'b1);
    check("p7.rst_rdy", in_ready, 1'b0);
    rst_n = 1'b1;
    clear_seq("p7");
    cyc();
    chk_wr("p7.quiet", 1'b0, 4'h0, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
